// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALUCTL_W = 4;
  localparam int unsigned OP_W = 7;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRPC   = 4'd12,
    S_FAULT    = 4'd13
  } state_t;

  localparam logic [ALUCTL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALUCTL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALUCTL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALUCTL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALUCTL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALUCTL_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [ALUCTL_W-1:0] ALU_SLTU = 4'b0110;
  localparam logic [ALUCTL_W-1:0] ALU_SLL  = 4'b0111;
  localparam logic [ALUCTL_W-1:0] ALU_SRL  = 4'b1000;
  localparam logic [ALUCTL_W-1:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format implied by the opcode; I-format covers everything else.
  function automatic logic [1:0] imm_sel(input logic [OP_W-1:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory bundle: IR fields and flags in, control strobes out.
interface mc_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       LtS;
  logic       LtU;
  logic       mem_ready;
  logic       mem_req;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       instr_done;
  logic [1:0] fault;

  modport master (
    input  op, funct3, funct7b5, Zero, LtS, LtU, mem_ready,
    output mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done, fault
  );

  modport slave (
    output op, funct3, funct7b5, Zero, LtS, LtU, mem_ready,
    input  mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done, fault
  );
endinterface

// File: rtl/mc_aludec.sv
// ALU operation decoder: ALUOp plus funct fields to ALUControl.
module mc_aludec
  import mc_ctrl_pkg::*;
(
  input  logic                op5,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic [1:0]          aluop,
  output logic [ALUCTL_W-1:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates sub from addi, whose IR[30] is immediate data
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alucontrol = ALU_SLL;
          3'b010:  alucontrol = ALU_SLT;
          3'b011:  alucontrol = ALU_SLTU;
          3'b100:  alucontrol = ALU_XOR;
          3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alucontrol = ALU_OR;
          default: alucontrol = ALU_AND;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM with memory handshake, wait timeout and fault state.
// Define CTRL_FULL_BRANCH_EN to add blt/bge/bltu/bgeu to the BRANCH state.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input logic clk,
  input logic reset,
  mc_controller_if.master bus
);

  state_t             state, state_next;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_next;
  logic [1:0]         fault_q, fault_next;
  logic [1:0]         aluop;
  logic               br_legal, br_take, wait_expired;
  logic               mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, instr_done;
  logic [1:0]         result_src, alu_src_a, alu_src_b, imm_src;
  logic [ALUCTL_W-1:0] alu_control;

  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT));

  // Branch condition and legality of the branch funct3
  always_comb begin
    br_legal = 1'b0;
    br_take  = 1'b0;
    case (bus.funct3)
      3'b000: begin br_legal = 1'b1; br_take = bus.Zero;  end
      3'b001: begin br_legal = 1'b1; br_take = ~bus.Zero; end
`ifdef CTRL_FULL_BRANCH_EN
      3'b100: begin br_legal = 1'b1; br_take = bus.LtS;  end
      3'b101: begin br_legal = 1'b1; br_take = ~bus.LtS; end
      3'b110: begin br_legal = 1'b1; br_take = bus.LtU;  end
      3'b111: begin br_legal = 1'b1; br_take = ~bus.LtU; end
`endif
      default: ;
    endcase
  end

`ifndef CTRL_FULL_BRANCH_EN
  logic unused_lt;
  assign unused_lt = bus.LtS ^ bus.LtU;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      fault_q  <= FAULT_NONE;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      fault_q  <= fault_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = '0;
    fault_next    = fault_q;
    mem_req       = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_B;
    imm_src       = IMM_I;
    aluop         = ALUOP_ADD;

    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = imm_sel(bus.op);
        case (bus.op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECUTER;
          OP_I:              state_next = S_EXECUTEI;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_BRANCH: begin
            if (br_legal) begin
              state_next = S_BRANCH;
            end else begin
              state_next = S_FAULT;
              fault_next = FAULT_ILLEGAL;
            end
          end
          default: begin
            state_next = S_FAULT;
            fault_next = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_A;
        alu_src_b  = SRCB_IMM;
        imm_src    = (bus.op == OP_STORE) ? IMM_S : IMM_I;
        state_next = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (bus.mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXECUTER: begin
        alu_src_a  = SRCA_A;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a  = SRCA_A;
        alu_src_b  = SRCB_IMM;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_A;
        aluop      = ALUOP_SUB;
        pc_write   = br_take;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = SRCA_A;
        alu_src_b  = SRCB_IMM;
        state_next = S_JALRPC;
      end
      S_JALRPC: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_FAULT: ;
      default: state_next = S_FETCH;
    endcase

    // Every memory state stalls on !mem_ready; ready at the limit still completes
    if (mem_req && !bus.mem_ready) begin
      if (wait_expired) begin
        state_next = S_FAULT;
        fault_next = FAULT_TIMEOUT;
      end else begin
        wait_cnt_next = wait_cnt + CNT_W'(1);
      end
    end

    if (reset) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

  mc_aludec u_aludec (
    .op5        (bus.op[5]),
    .funct3     (bus.funct3),
    .funct7b5   (bus.funct7b5),
    .aluop      (aluop),
    .alucontrol (alu_control)
  );

  assign bus.mem_req    = mem_req;
  assign bus.AdrSrc     = adr_src;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.PCWrite    = pc_write;
  assign bus.RegWrite   = reg_write;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ImmSrc     = imm_src;
  assign bus.ALUControl = alu_control;
  assign bus.instr_done = instr_done;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction expected cycle streams plus pinned literals.
module tb_mc_controller;

  localparam int unsigned TIMEOUT = 15;
  localparam logic [6:0] L_LOAD = 7'b0000011, L_STORE = 7'b0100011, L_R = 7'b0110011,
                         L_I = 7'b0010011, L_BR = 7'b1100011, L_JAL = 7'b1101111,
                         L_JALR = 7'b1100111;

  typedef struct packed {
    logic       mem_req, adr, mw, irw, pcw, rw, done;
    logic [1:0] rs, sa, sb, imm;
    logic [3:0] alu;
    logic [1:0] flt;
    logic       c_adr, c_rs, c_alu, c_imm, c_flt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  mc_controller_if bus ();

  mc_controller #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t       expq[$];
  string      tagq[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  string      cur_tag = "init";
  logic [1:0] cur_fault = 2'b00;
  int         ci, nreq, done_at;
  logic [3:0] alu_tr[64];
  logic       pcw_tr[64];
  logic       mw_tr[64];
  logic [1:0] flt_tr[64];

  // ---------------- expected-cycle builders ----------------
  function automatic exp_t blank();
    exp_t e;
    e = '0;
    e.flt = cur_fault;
    e.c_flt = 1'b1;
    return e;
  endfunction

  function automatic exp_t with_alu(input exp_t b, input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [3:0] alu);
    exp_t e;
    e = b;
    e.c_alu = 1'b1; e.sa = sa; e.sb = sb; e.alu = alu;
    return e;
  endfunction

  function automatic exp_t r_fetch(input logic rdy);
    exp_t e;
    e = with_alu(blank(), 2'b00, 2'b10, 4'b0000);
    e.mem_req = 1'b1; e.c_adr = 1'b1; e.adr = 1'b0;
    e.irw = rdy; e.pcw = rdy; e.c_rs = 1'b1; e.rs = 2'b10;
    return e;
  endfunction

  function automatic exp_t r_decode(input logic [6:0] o);
    exp_t e;
    e = with_alu(blank(), 2'b01, 2'b01, 4'b0000);
    e.c_imm = 1'b1;
    case (o)
      L_STORE: e.imm = 2'b01;
      L_BR:    e.imm = 2'b10;
      L_JAL:   e.imm = 2'b11;
      L_LOAD, L_R, L_I, L_JALR: e.imm = 2'b00;
      default: e.c_imm = 1'b0;
    endcase
    return e;
  endfunction

  function automatic exp_t r_memadr(input logic store);
    exp_t e;
    e = with_alu(blank(), 2'b10, 2'b01, 4'b0000);
    e.c_imm = 1'b1; e.imm = store ? 2'b01 : 2'b00;
    return e;
  endfunction

  function automatic exp_t r_mem(input int kind, input logic rdy);
    exp_t e;
    if (kind == 0) return r_fetch(rdy);
    e = blank();
    e.mem_req = 1'b1; e.c_adr = 1'b1; e.adr = 1'b1;
    if (kind == 2) begin e.mw = 1'b1; e.done = rdy; end
    return e;
  endfunction

  function automatic exp_t r_wb(input logic [1:0] rs);
    exp_t e;
    e = blank();
    e.c_rs = 1'b1; e.rs = rs; e.rw = 1'b1; e.done = 1'b1;
    return e;
  endfunction

  function automatic exp_t r_exec(input logic isimm, input logic [3:0] alu);
    exp_t e;
    e = with_alu(blank(), 2'b10, isimm ? 2'b01 : 2'b00, alu);
    e.c_imm = isimm; e.imm = 2'b00;
    return e;
  endfunction

  function automatic exp_t r_branch(input logic take);
    exp_t e;
    e = with_alu(blank(), 2'b10, 2'b00, 4'b0001);
    e.c_rs = 1'b1; e.rs = 2'b00; e.pcw = take; e.done = 1'b1;
    return e;
  endfunction

  function automatic exp_t r_pclink();
    exp_t e;
    e = with_alu(blank(), 2'b01, 2'b10, 4'b0000);
    e.c_rs = 1'b1; e.rs = 2'b00; e.pcw = 1'b1;
    return e;
  endfunction

  function automatic exp_t r_reset(input logic chk_flt);
    exp_t e;
    e = blank();
    e.c_flt = chk_flt;
    return e;
  endfunction

  function automatic logic [3:0] alu_exp(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 4'b0001 : 4'b0000;
      3'b001:  return 4'b0111;
      3'b010:  return 4'b0101;
      3'b011:  return 4'b0110;
      3'b100:  return 4'b0100;
      3'b101:  return f7 ? 4'b1001 : 4'b1000;
      3'b110:  return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction

  // ---------------- compare process ----------------
  exp_t  ce;
  string ctag;
  logic  bad;
  always @(negedge clk) begin
    if (expq.size() != 0) begin
      ce   = expq.pop_front();
      ctag = tagq.pop_front();
      bad  = 1'b0;
      if ({bus.mem_req, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.instr_done}
          !== {ce.mem_req, ce.mw, ce.irw, ce.pcw, ce.rw, ce.done}) bad = 1'b1;
      if (ce.c_adr && bus.AdrSrc !== ce.adr) bad = 1'b1;
      if (ce.c_rs && bus.ResultSrc !== ce.rs) bad = 1'b1;
      if (ce.c_alu && {bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl} !== {ce.sa, ce.sb, ce.alu}) bad = 1'b1;
      if (ce.c_imm && bus.ImmSrc !== ce.imm) bad = 1'b1;
      if (ce.c_flt && bus.fault !== ce.flt) bad = 1'b1;
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s: got req=%b adr=%b mw=%b irw=%b pcw=%b rw=%b done=%b rs=%b sa=%b sb=%b imm=%b alu=%b flt=%b; expected req=%b adr=%b mw=%b irw=%b pcw=%b rw=%b done=%b rs=%b sa=%b sb=%b imm=%b alu=%b flt=%b",
                 ctag, bus.mem_req, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite,
                 bus.instr_done, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl,
                 bus.fault, ce.mem_req, ce.adr, ce.mw, ce.irw, ce.pcw, ce.rw, ce.done, ce.rs, ce.sa,
                 ce.sb, ce.imm, ce.alu, ce.flt);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cycle(input logic rdy, input exp_t e);
    bus.mem_ready = rdy;
    expq.push_back(e);
    tagq.push_back($sformatf("%s@%0d", cur_tag, ci + 1));
    @(negedge clk);
    ci++;
    if (ci < 64) begin
      alu_tr[ci] = bus.ALUControl;
      pcw_tr[ci] = bus.PCWrite;
      mw_tr[ci]  = bus.MemWrite;
      flt_tr[ci] = bus.fault;
    end
    if (bus.mem_req === 1'b1) nreq++;
    if (bus.instr_done === 1'b1 && done_at == 0) done_at = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input int got, input int exp_v);
    n_tests++;
    if (got != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cur_tag = "reset";
    cycle(1'b0, r_reset(1'b0));
    cur_fault = 2'b00;
    cycle(1'b1, r_reset(1'b1));
    reset = 1'b0;
  endtask

  task automatic fault_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(logic'(i % 2), blank());
  endtask

  // w not-ready cycles, then ready; more than TIMEOUT waits ends in a timeout fault
  task automatic mem_phase(input int kind, input int w, output bit to);
    to = 1'b0;
    for (int i = 0; i < w && i <= int'(TIMEOUT); i++) cycle(1'b0, r_mem(kind, 1'b0));
    if (w > int'(TIMEOUT)) begin
      to = 1'b1;
      cur_fault = 2'b10;
    end else begin
      cycle(1'b1, r_mem(kind, 1'b1));
    end
  endtask

  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input logic lts, input logic ltu,
                           input int fw, input int mw);
    bit to, legal, take, faulted;
    cur_tag = tag; ci = 0; nreq = 0; done_at = 0; faulted = 1'b0;
    bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z; bus.LtS = lts; bus.LtU = ltu;
    mem_phase(0, fw, to);
    if (to) faulted = 1'b1;
    else begin
      cycle(1'b1, r_decode(o));
      case (o)
        L_LOAD: begin
          cycle(1'b1, r_memadr(1'b0));
          mem_phase(1, mw, to);
          if (to) faulted = 1'b1; else cycle(1'b1, r_wb(2'b01));
        end
        L_STORE: begin
          cycle(1'b1, r_memadr(1'b1));
          mem_phase(2, mw, to);
          faulted = to;
        end
        L_R, L_I: begin
          cycle(1'b1, r_exec(o == L_I, alu_exp(o, f3, f7)));
          cycle(1'b1, r_wb(2'b00));
        end
        L_BR: begin
          legal = (f3 == 3'b000) || (f3 == 3'b001);
          take  = (f3 == 3'b000) ? z : ~z;
`ifdef CTRL_FULL_BRANCH_EN
          if (f3[2]) begin
            legal = 1'b1;
            take  = (f3[1] ? ltu : lts) ^ f3[0];
          end
`endif
          if (legal) cycle(1'b1, r_branch(take));
          else begin cur_fault = 2'b01; faulted = 1'b1; end
        end
        L_JAL: begin
          cycle(1'b1, r_pclink());
          cycle(1'b1, r_wb(2'b00));
        end
        L_JALR: begin
          cycle(1'b1, r_exec(1'b1, 4'b0000));
          cycle(1'b1, r_pclink());
          cycle(1'b1, r_wb(2'b00));
        end
        default: begin cur_fault = 2'b01; faulted = 1'b1; end
      endcase
    end
    if (faulted) fault_cycles(4);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
    bus.Zero = 1'b0; bus.LtS = 1'b0; bus.LtU = 1'b0; bus.mem_ready = 1'b0;
    do_reset();

    run_instr("sub", L_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    check_lit("sub_done_cycle", done_at, 4);
    check_lit("sub_alucontrol", int'(alu_tr[3]), 1);
    run_instr("sra", L_R, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    check_lit("sra_alucontrol", int'(alu_tr[3]), 9);
    run_instr("or", L_R, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    run_instr("addi_f7", L_I, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    check_lit("addi_alucontrol", int'(alu_tr[3]), 0);
    run_instr("srli", L_I, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    run_instr("lw_wait3", L_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3);
    check_lit("lw_wait3_done", done_at, 8);
    check_lit("lw_wait3_req_cycles", nreq, 5);
    run_instr("lw_split", L_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 10, 10);
    check_lit("lw_split_done", done_at, 25);
    run_instr("sw", L_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    check_lit("sw_done", done_at, 4);
    run_instr("sw_wait15", L_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 15);
    check_lit("sw_wait15_done", done_at, 19);

    run_instr("beq_nt", L_BR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    check_lit("beq_nt_pcwrite", int'(pcw_tr[3]), 0);
    check_lit("beq_nt_done", done_at, 3);
    run_instr("beq_t", L_BR, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    check_lit("beq_t_pcwrite", int'(pcw_tr[3]), 1);
    run_instr("bne_t", L_BR, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("jal", L_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    check_lit("jal_done", done_at, 4);
    run_instr("jalr", L_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    check_lit("jalr_done", done_at, 5);
    run_instr("fetch_wait15", L_I, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 15, 0);
    check_lit("fetch_wait15_done", done_at, 19);

    run_instr("blt", L_BR, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
`ifdef CTRL_FULL_BRANCH_EN
    check_lit("blt_pcwrite", int'(pcw_tr[3]), 1);
    run_instr("bgeu", L_BR, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    check_lit("bgeu_pcwrite", int'(pcw_tr[3]), 0);
`else
    check_lit("blt_fault", int'(flt_tr[3]), 1);
    do_reset();
`endif

    run_instr("illegal", 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    check_lit("illegal_fault", int'(flt_tr[3]), 1);
    do_reset();

    run_instr("fetch_timeout", L_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 20, 0);
    check_lit("fetch_timeout_req_cycles", nreq, 16);
    check_lit("fetch_timeout_fault", int'(flt_tr[17]), 2);
    do_reset();

    run_instr("lw_timeout", L_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16);
    check_lit("lw_timeout_fault", int'(flt_tr[20]), 2);
    do_reset();

    cur_tag = "rst_memwrite"; ci = 0; nreq = 0; done_at = 0;
    bus.op = L_STORE; bus.funct3 = 3'b010;
    cycle(1'b1, r_fetch(1'b1));
    cycle(1'b1, r_decode(L_STORE));
    cycle(1'b1, r_memadr(1'b1));
    reset = 1'b1;
    cycle(1'b0, r_reset(1'b1));
    reset = 1'b0;
    check_lit("rst_memwrite_mw", int'(mw_tr[4]), 0);
    run_instr("after_rst", L_I, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    check_lit("after_rst_done", done_at, 4);

    if (expq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle RV32I control unit: a Moore FSM, plus a combinational ALU decoder, that sequences one instruction over 3–5 cycles through a single shared memory port and one ALU. It drives the multicycle datapath (PC, IR, OldPC, A/B, ALUOut, Data registers) and replaces the single-cycle control path. It adds a memory ready/request handshake, a wait-state timeout, a fault state for illegal instructions, and optional full branch support.

## Interface
- `TIMEOUT`, default 15: maximum cycles spent waiting on `mem_ready` in one memory state before faulting (1..2^`CNT_W`-1).
- `CNT_W`, default 4: width of the wait counter.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `op` in 7: IR[6:0].
- `funct3` in 3: IR[14:12].
- `funct7b5` in 1: IR[30].
- `Zero` in 1: ALU result == 0.
- `LtS` in 1: signed A<B from ALU.
- `LtU` in 1: unsigned A<B from ALU.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access requested.
- `AdrSrc` out 1: 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: store strobe.
- `IRWrite` out 1: load IR and OldPC.
- `PCWrite` out 1: load PC from Result.
- `RegWrite` out 1: register file write.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 A.
- `ALUSrcB` out 2: 00 B, 01 Imm, 10 const 4.
- `ImmSrc` out 2: 00 I, 01 S, 10 B, 11 J.
- `ALUControl` out 4: ALU operation.
- `instr_done` out 1: pulse in the final cycle of each retired instruction.
- `fault` out 2: 00 none, 01 illegal instruction, 10 memory timeout. Sticky until reset.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, JALR, JALRPC, FAULT.
- FETCH:
  - Outputs: `mem_req`=1, `AdrSrc`=0, ALU computes PC+4 (SrcA 00, SrcB 10, ADD), `ResultSrc`=10.
  - On `mem_ready`: `IRWrite`=1, `PCWrite`=1, go to DECODE. Otherwise stay.
- DECODE:
  - ALU computes OldPC+Imm (SrcA 01, SrcB 01, `ImmSrc` from `op`) into ALUOut for branch/jal targets.
  - Next state by `op`:
    - 0000011 / 0100011 → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1100011 → BRANCH.
    - 1101111 → JAL.
    - 1100111 → JALR.
    - Any other `op` → FAULT (`fault`=01).
- MEMADR: A+Imm. Next state is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: `mem_req`=1, `AdrSrc`=1. Go to MEMWB on `mem_ready`.
- MEMWB: `ResultSrc`=01, `RegWrite`=1, `instr_done`=1 → FETCH.
- MEMWRITE: `mem_req`=1, `AdrSrc`=1, `MemWrite`=1. Both are held until `mem_ready`; then `instr_done`=1 → FETCH.
- EXECUTER / EXECUTEI: A op B or A op Imm → ALUWB.
- ALUWB: `ResultSrc`=00, `RegWrite`=1, `instr_done`=1 → FETCH.
- BRANCH: A−B (SUB), `ResultSrc`=00, `PCWrite`=take, `instr_done`=1 → FETCH.
  - take = `Zero` for beq (000) and ~`Zero` for bne (001).
  - Other funct3 values: see Configuration.
- JAL: OldPC+4 computed; `ResultSrc`=00 (target), `PCWrite`=1 → ALUWB.
- JALR:
  - JALR state: A+Imm → JALRPC.
  - JALRPC: `PCWrite`=1 from ALUOut (`ResultSrc`=00) while the ALU computes OldPC+4 → ALUWB.
- FAULT: all enables 0, `instr_done`=0. Terminal until reset.
- ALU decoding:
  - ALUOp 00 → ADD; 01 → SUB; 10 → decode funct3.
  - SUB only when `op`[5]=1 and `funct7b5`=1 with funct3=000.
  - SRA when funct3=101 and `funct7b5`=1.

## Timing
- Zero-wait latencies in cycles:
  - lw 5; sw 4; R-type 4; I-type 4.
  - branch 3; jal 4; jalr 5.
  - Each wait cycle on `mem_ready` adds 1.
- Wait counter:
  - Clears on entry to each memory state and increments every cycle that `mem_ready`=0 in that state.
  - When it equals `TIMEOUT` and `mem_ready`=0 → FAULT, `fault`=10.
  - `mem_ready`=1 in the same cycle the counter reaches `TIMEOUT` wins: the access completes.
- `mem_ready` is ignored outside FETCH, MEMREAD and MEMWRITE.
- All outputs are Moore except `IRWrite`, `PCWrite` (FETCH) and `instr_done` (MEMWRITE), which are gated by `mem_ready`.
- Reset:
  - While `reset`=1, `mem_req`, `MemWrite`, `IRWrite`, `PCWrite`, `RegWrite` and `instr_done` are forced 0.
  - On the sampling edge: state ← FETCH, counter ← 0, `fault` ← 00.
  - Reset mid-access aborts the access with no write.

## Configuration
- `CTRL_FULL_BRANCH_EN` defined: BRANCH state also takes:
  - blt (100) on `LtS`; bge (101) on ~`LtS`.
  - bltu (110) on `LtU`; bgeu (111) on ~`LtU`.
- Undefined:
  - `LtS` and `LtU` are ignored.
  - Branch funct3 values other than 000/001 go from DECODE to FAULT with `fault`=01.

## Structure
- Package `mc_ctrl_pkg`:
  - State enum (4-bit).
  - ALUControl constants: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
  - Opcode constants.
  - Fault codes.
  - ResultSrc, ALUSrcA and ALUSrcB encodings.
- One sub-module: `mc_aludec` (combinational: `op`[5], `funct3`, `funct7b5`, ALUOp → `ALUControl`).

## Test plan
- Reset, then `op`=0110011, `funct3`=000, `funct7b5`=1, `mem_ready`=1 → FETCH, DECODE, EXECUTER (`ALUControl`=0001), then ALUWB with `RegWrite`=1 and `instr_done`=1 in cycle 4.
- lw with `mem_ready` low for 3 cycles in MEMREAD → `mem_req` and `AdrSrc`=1 held 4 cycles; MEMWB follows; 8 cycles total.
- beq with `Zero`=0 → `PCWrite`=0 in BRANCH; repeat with `Zero`=1 → `PCWrite`=1, `ResultSrc`=00.
- `op`=0000000 → FAULT after DECODE, `fault`=01, no enable ever asserted again until `reset`.
- `mem_ready` held 0 in FETCH with `TIMEOUT`=15 → `fault`=10 after 16 cycles; reset asserted in MEMWRITE → `MemWrite`=0 that cycle, FETCH next.
- blt (funct3 100) with `LtS`=1 → `PCWrite`=1 when `CTRL_FULL_BRANCH_EN` is defined; `fault`=01 when it is not.
